// File: rtl/writeback.sv
// LC-3 writeback stage: retires the selected result into an 8x16 register file,
// updates the N/Z/P status, and serves two asynchronous read ports to execute.
module writeback #(
  parameter  int DATA_W = 16,
  parameter  int NREGS  = 8,
  localparam int IDX_W  = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] memout,
  input  logic [1:0]        W_Control,
  input  logic [IDX_W-1:0]  dr,
  input  logic [IDX_W-1:0]  sr1,
  input  logic [IDX_W-1:0]  sr2,
  output logic [DATA_W-1:0] VSR1,
  output logic [DATA_W-1:0] VSR2,
  output logic [2:0]        psr
);

  logic [DATA_W-1:0] regfile_r [NREGS];
  logic [2:0]        psr_r;
  logic [DATA_W-1:0] wr_data_s;
  logic              wr_en_s;

  // Exactly one of N/Z/P is set for any retired value.
  function automatic logic [2:0] nzp_f(input logic [DATA_W-1:0] value);
    if (value[DATA_W-1]) begin
      nzp_f = 3'b100;
    end else if (value == {DATA_W{1'b0}}) begin
      nzp_f = 3'b010;
    end else begin
      nzp_f = 3'b001;
    end
  endfunction

  // Result select; code 3 and a disabled stage both suppress the write.
  always_comb begin
    wr_data_s = {DATA_W{1'b0}};
    wr_en_s   = 1'b0;
    case (W_Control)
      2'd0: begin
        wr_data_s = aluout;
        wr_en_s   = enable_writeback;
      end
      2'd1: begin
        wr_data_s = memout;
        wr_en_s   = enable_writeback;
      end
      2'd2: begin
        wr_data_s = pcout;
        wr_en_s   = enable_writeback;
      end
      default: begin
        wr_data_s = {DATA_W{1'b0}};
        wr_en_s   = 1'b0;
      end
    endcase
  end

  // Register file and status update; reset discards a coincident write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regfile_r[i] <= {DATA_W{1'b0}};
      end
      psr_r <= 3'b000;
    end else if (wr_en_s) begin
      regfile_r[dr] <= wr_data_s;
      psr_r         <= nzp_f(wr_data_s);
    end
  end

  // Reads return pre-edge contents: no bypass of a same-cycle write.
  assign VSR1 = regfile_r[sr1];
  assign VSR2 = regfile_r[sr2];
  assign psr  = psr_r;

endmodule

// File: tb/tb_writeback.sv
// Directed scoreboard bench for writeback: the driver queues expected read-port
// and psr values per cycle; a negedge monitor pops and compares them.
module tb_writeback;

  logic        clock;
  logic        reset;
  logic        enable_writeback;
  logic [15:0] aluout;
  logic [15:0] pcout;
  logic [15:0] memout;
  logic [1:0]  W_Control;
  logic [2:0]  dr;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [15:0] VSR1;
  logic [15:0] VSR2;
  logic [2:0]  psr;

  typedef struct packed {
    logic        chk;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [2:0]  ep;
    logic [31:0] tag;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  writeback dut (
    .clock            (clock),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .aluout           (aluout),
    .pcout            (pcout),
    .memout           (memout),
    .W_Control        (W_Control),
    .dr               (dr),
    .sr1              (sr1),
    .sr2              (sr2),
    .VSR1             (VSR1),
    .VSR2             (VSR2),
    .psr              (psr)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.chk) begin
        vectors++;
        if (VSR1 !== e.e1 || VSR2 !== e.e2 || psr !== e.ep) begin
          miscompares++;
          $display("FAIL %s sr1=%0d sr2=%0d: got VSR1=%h VSR2=%h psr=%b, expected VSR1=%h VSR2=%h psr=%b",
                   e.tag, sr1, sr2, VSR1, VSR2, psr, e.e1, e.e2, e.ep);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic en, input logic [1:0] wc, input logic [2:0] d,
                     input logic [15:0] a, input logic [15:0] m, input logic [15:0] p,
                     input logic [2:0] s1, input logic [2:0] s2, input logic chk,
                     input logic [15:0] e1, input logic [15:0] e2, input logic [2:0] ep,
                     input logic [31:0] tag);
    exp_t e;
    reset            = r;
    enable_writeback = en;
    W_Control        = wc;
    dr               = d;
    aluout           = a;
    memout           = m;
    pcout            = p;
    sr1              = s1;
    sr2              = s2;
    e.chk = chk;
    e.e1  = e1;
    e.e2  = e2;
    e.ep  = ep;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] old_v [8];
    logic [15:0] exp2;
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1; enable_writeback = 1'b1; W_Control = 2'd0; dr = 3'd0;
    aluout = 16'hFFFF; memout = 16'h0000; pcout = 16'h0000; sr1 = 3'd0; sr2 = 3'd0;
    @(posedge clock);
    #1;

    // Reset held two cycles against an enabled write of FFFF
    cyc(1'b1, 1'b1, 2'd0, 3'd0, 16'hFFFF, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 16'h0, 16'h0, 3'b000, "RST ");
    cyc(1'b1, 1'b1, 2'd0, 3'd0, 16'hFFFF, 16'h0, 16'h0, 3'd0, 3'd0, 1'b0, 16'h0, 16'h0, 3'b000, "RST ");
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 3'(i), 3'(7 - i), 1'b1,
          16'h0000, 16'h0000, 3'b000, "RSTV");
    end

    // Mux select and psr; each expectation reflects state before this cycle's edge
    cyc(1'b0, 1'b1, 2'd0, 3'd3, 16'h0005, 16'h0, 16'h0, 3'd3, 3'd3, 1'b1, 16'h0000, 16'h0000, 3'b000, "ALU ");
    cyc(1'b0, 1'b1, 2'd1, 3'd4, 16'h0, 16'h8000, 16'h0, 3'd3, 3'd4, 1'b1, 16'h0005, 16'h0000, 3'b001, "MEM ");
    cyc(1'b0, 1'b1, 2'd2, 3'd5, 16'h0, 16'h0, 16'h3010, 3'd4, 3'd5, 1'b1, 16'h8000, 16'h0000, 3'b100, "PC  ");
    cyc(1'b0, 1'b1, 2'd0, 3'd2, 16'h0000, 16'h0, 16'h0, 3'd5, 3'd2, 1'b1, 16'h3010, 16'h0000, 3'b001, "ZERO");
    cyc(1'b0, 1'b1, 2'd3, 3'd2, 16'h1234, 16'h0, 16'h0, 3'd2, 3'd5, 1'b1, 16'h0000, 16'h3010, 3'b010, "WC3 ");
    cyc(1'b0, 1'b0, 2'd0, 3'd2, 16'h7777, 16'h0, 16'h0, 3'd2, 3'd2, 1'b1, 16'h0000, 16'h0000, 3'b010, "DIS ");
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd2, 3'd3, 1'b1, 16'h0000, 16'h0005, 3'b010, "HOLD");

    // Read-during-write returns the old value
    cyc(1'b0, 1'b1, 2'd0, 3'd6, 16'h00AA, 16'h0, 16'h0, 3'd2, 3'd2, 1'b1, 16'h0000, 16'h0000, 3'b010, "R6AA");
    cyc(1'b0, 1'b1, 2'd0, 3'd6, 16'h0055, 16'h0, 16'h0, 3'd6, 3'd6, 1'b1, 16'h00AA, 16'h00AA, 3'b001, "RDW ");
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd6, 3'd6, 1'b1, 16'h0055, 16'h0055, 3'b001, "RDWN");

    // Back-to-back fill of R0..R7 with 1000+i
    old_v = '{16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h8000, 16'h3010, 16'h0055, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      exp2 = (i == 0) ? old_v[7] : 16'h1000 + 16'(i - 1);
      cyc(1'b0, 1'b1, 2'd0, 3'(i), 16'h1000 + 16'(i), 16'h0, 16'h0, 3'(i), 3'((i + 7) % 8), 1'b1,
          old_v[i], exp2, 3'b001, "FILL");
    end

    // Every read-port pair after the fill
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        cyc(1'b0, 1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 3'(a), 3'(b), 1'b1,
            16'h1000 + 16'(a), 16'h1000 + 16'(b), 3'b001, "PAIR");
      end
    end

    // Reset mid-stream discards a coincident write
    cyc(1'b0, 1'b1, 2'd0, 3'd1, 16'hBEEF, 16'h0, 16'h0, 3'd1, 3'd1, 1'b1, 16'h1001, 16'h1001, 3'b001, "BEEF");
    cyc(1'b1, 1'b1, 2'd0, 3'd1, 16'h1111, 16'h0, 16'h0, 3'd1, 3'd1, 1'b1, 16'hBEEF, 16'hBEEF, 3'b100, "MRST");
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd1, 3'd0, 1'b1, 16'h0000, 16'h0000, 3'b000, "POST");
    cyc(1'b0, 1'b1, 2'd0, 3'd7, 16'hFFFE, 16'h0, 16'h0, 3'd7, 3'd7, 1'b1, 16'h0000, 16'h0000, 3'b000, "NEXT");
    cyc(1'b0, 1'b0, 2'd0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd7, 3'd1, 1'b1, 16'hFFFE, 16'h0000, 3'b100, "NEG ");

    repeat (3) @(posedge clock);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL DRAIN: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
